// File: rtl/arp_rx_parser_pkg.sv
// ARP receive parser shared definitions: protocol constants, FSM encoding,
// captured-field payload and the byte-offset-to-field placement helper.
package arp_rx_parser_pkg;

  localparam int unsigned BYTE_CNT_W = 6;
  localparam int unsigned ARP_LEN    = 28;
  localparam int unsigned CNT_SAT    = 32;

  localparam logic [15:0] HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  HLEN_ETH   = 8'd6;
  localparam logic [7:0]  PLEN_IPV4  = 8'd4;
  localparam logic [15:0] OPER_REQ   = 16'h0001;
  localparam logic [15:0] OPER_REP   = 16'h0002;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_HOLD   = 2'd2
  } arp_state_e;

  typedef struct packed {
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
  } arp_fields_t;

  // Place one payload byte into the field it belongs to; THA and padding are dropped.
  function automatic arp_fields_t put_byte(input arp_fields_t f,
                                           input logic [BYTE_CNT_W-1:0] off,
                                           input logic [7:0] b);
    arp_fields_t r;
    r = f;
    case (off)
      6'd0:  r.htype[15:8] = b;
      6'd1:  r.htype[7:0]  = b;
      6'd2:  r.ptype[15:8] = b;
      6'd3:  r.ptype[7:0]  = b;
      6'd4:  r.hlen        = b;
      6'd5:  r.plen        = b;
      6'd6:  r.oper[15:8]  = b;
      6'd7:  r.oper[7:0]   = b;
      6'd8:  r.sha[47:40]  = b;
      6'd9:  r.sha[39:32]  = b;
      6'd10: r.sha[31:24]  = b;
      6'd11: r.sha[23:16]  = b;
      6'd12: r.sha[15:8]   = b;
      6'd13: r.sha[7:0]    = b;
      6'd14: r.spa[31:24]  = b;
      6'd15: r.spa[23:16]  = b;
      6'd16: r.spa[15:8]   = b;
      6'd17: r.spa[7:0]    = b;
      6'd24: r.tpa[31:24]  = b;
      6'd25: r.tpa[23:16]  = b;
      6'd26: r.tpa[15:8]   = b;
      6'd27: r.tpa[7:0]    = b;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arp_field_capture.sv
// Lane-to-offset byte capture for the ARP parser. fields_c_o is the field view
// including the beat accepted this cycle, so a frame-status strobe arriving
// with the last beat sees the complete header.
module arp_field_capture
  import arp_rx_parser_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    beat_acc_i,
  input  logic [8*DATA_BYTES-1:0] data_i,
  input  logic [BYTE_CNT_W-1:0]   cnt_i,
  output arp_fields_t             fields_c_o
);

  arp_fields_t fields_q;

  // Merge every lane of the accepted beat at its wire offset (MSB lane first).
  always_comb begin
    fields_c_o = fields_q;
    if (beat_acc_i) begin
      for (int unsigned l = 0; l < DATA_BYTES; l++) begin
        fields_c_o = put_byte(fields_c_o, cnt_i + BYTE_CNT_W'(l),
                              data_i[8*(DATA_BYTES-1-l) +: 8]);
      end
    end
  end

  // Field latches, wiped whenever the parser returns to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fields_q <= '0;
    end else if (clr_i) begin
      fields_q <= '0;
    end else begin
      fields_q <= fields_c_o;
    end
  end

endmodule

// File: rtl/arp_rx_parser.sv
// ARP receive parser: gathers one ARP payload per frame, validates it against
// the local IPv4 address on the frame-status strobe and offers one event.
// Optional build macro: ARP_RX_STATS_EN adds saturating request/reply/drop counters.
module arp_rx_parser
  import arp_rx_parser_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    i_sys_clk,
  input  logic                    i_rst,
  input  logic [31:0]             i_cfg_local_ip,
  input  logic                    i_rx_valid,
  input  logic [8*DATA_BYTES-1:0] i_rx_data,
  output logic                    o_rx_ready,
  input  logic                    i_bad_packet_en,
  input  logic                    i_bad_packet,
  output logic                    o_evt_valid,
  input  logic                    i_evt_ready,
  output logic                    o_evt_need_reply,
  output logic                    o_evt_gratuitous,
  output logic [31:0]             o_evt_ip,
  output logic [47:0]             o_evt_mac,
  output logic                    o_busy
`ifdef ARP_RX_STATS_EN
  ,
  output logic [CNT_W-1:0]        o_cnt_req,
  output logic [CNT_W-1:0]        o_cnt_rep,
  output logic [CNT_W-1:0]        o_cnt_drop
`endif
);

  if (!(DATA_BYTES == 1 || DATA_BYTES == 2 || DATA_BYTES == 4) || CNT_W == 0) begin : g_param_check
    $error("arp_rx_parser: DATA_BYTES must be 1, 2 or 4 and CNT_W nonzero");
  end

  arp_state_e              state_q;
  logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_CNT_W:0]     cnt_sum;
  logic                    beat_acc, frame_ok, to_hold, drop, handshake, clr;
  arp_fields_t             fields_c;

  arp_field_capture #(.DATA_BYTES(DATA_BYTES)) u_capture (
    .clk_i      (i_sys_clk),
    .rst_i      (i_rst),
    .clr_i      (clr),
    .beat_acc_i (beat_acc),
    .data_i     (i_rx_data),
    .cnt_i      (cnt_q),
    .fields_c_o (fields_c)
  );

  // Byte count, frame verdict and FSM transition conditions for this cycle.
  always_comb begin
    beat_acc = i_rx_valid && o_rx_ready;
    cnt_sum  = (BYTE_CNT_W+1)'(cnt_q) + (BYTE_CNT_W+1)'(DATA_BYTES);
    cnt_d    = cnt_q;
    if (beat_acc) begin
      cnt_d = (cnt_sum >= (BYTE_CNT_W+1)'(CNT_SAT)) ? BYTE_CNT_W'(CNT_SAT)
                                                    : BYTE_CNT_W'(cnt_sum);
    end
    frame_ok  = (cnt_d >= BYTE_CNT_W'(ARP_LEN)) &&
                (fields_c.htype == HTYPE_ETH) && (fields_c.ptype == PTYPE_IPV4) &&
                (fields_c.hlen == HLEN_ETH) && (fields_c.plen == PLEN_IPV4) &&
                ((fields_c.oper == OPER_REQ) || (fields_c.oper == OPER_REP)) &&
                (fields_c.tpa == i_cfg_local_ip);
    to_hold   = (state_q == ST_GATHER) && i_bad_packet_en && !i_bad_packet && frame_ok;
    drop      = (state_q == ST_GATHER) && i_bad_packet_en && (i_bad_packet || !frame_ok);
    handshake = (state_q == ST_HOLD) && o_evt_valid && i_evt_ready;
    clr       = drop || handshake;
  end

  // Parser FSM with registered handshake, status and event payload outputs.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      o_rx_ready       <= 1'b1;
      o_busy           <= 1'b0;
      o_evt_valid      <= 1'b0;
      o_evt_need_reply <= 1'b0;
      o_evt_gratuitous <= 1'b0;
      o_evt_ip         <= '0;
      o_evt_mac        <= '0;
    end else begin
      cnt_q <= clr ? '0 : cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (beat_acc) begin
            state_q <= ST_GATHER;
            o_busy  <= 1'b1;
          end
        end
        ST_GATHER: begin
          if (to_hold) begin
            state_q          <= ST_HOLD;
            o_rx_ready       <= 1'b0;
            o_evt_valid      <= 1'b1;
            o_evt_need_reply <= (fields_c.oper == OPER_REQ);
            o_evt_gratuitous <= (fields_c.spa == fields_c.tpa);
            o_evt_ip         <= fields_c.spa;
            o_evt_mac        <= fields_c.sha;
          end else if (drop) begin
            state_q <= ST_IDLE;
            o_busy  <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            state_q          <= ST_IDLE;
            o_rx_ready       <= 1'b1;
            o_busy           <= 1'b0;
            o_evt_valid      <= 1'b0;
            o_evt_need_reply <= 1'b0;
            o_evt_gratuitous <= 1'b0;
            o_evt_ip         <= '0;
            o_evt_mac        <= '0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          o_rx_ready <= 1'b1;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARP_RX_STATS_EN
  // Saturating per-frame statistics.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt_req  <= '0;
      o_cnt_rep  <= '0;
      o_cnt_drop <= '0;
    end else begin
      if (to_hold && (fields_c.oper == OPER_REQ) && (o_cnt_req != '1))
        o_cnt_req <= o_cnt_req + CNT_W'(1);
      if (to_hold && (fields_c.oper == OPER_REP) && (o_cnt_rep != '1))
        o_cnt_rep <= o_cnt_rep + CNT_W'(1);
      if (drop && (o_cnt_drop != '1))
        o_cnt_drop <= o_cnt_drop + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_arp_rx_parser.sv
// Directed bench for arp_rx_parser: a DATA_BYTES=1 and a DATA_BYTES=4 instance
// share clock and reset. Honours ARP_RX_STATS_EN when defined.
module tb_arp_rx_parser;

  localparam logic [31:0] LOCAL = 32'hC0A80102;

  logic        clk, rst;
  logic [31:0] local_ip;

  logic        v1, rdy1, ben1, bad1, evv1, er1, nr1, gr1, busy1;
  logic [7:0]  d1;
  logic [31:0] ip1;
  logic [47:0] mac1;

  logic        v4, rdy4, ben4, bad4, evv4, er4, nr4, gr4, busy4;
  logic [31:0] d4;
  logic [31:0] ip4;
  logic [47:0] mac4;

`ifdef ARP_RX_STATS_EN
  logic [15:0] req1, rep1, drop1, req4, rep4, drop4;
`endif

  logic [7:0] frm [0:63];
  int n_chk, n_fail;

  arp_rx_parser #(.DATA_BYTES(1), .CNT_W(16)) u_dut1 (
    .i_sys_clk(clk), .i_rst(rst), .i_cfg_local_ip(local_ip),
    .i_rx_valid(v1), .i_rx_data(d1), .o_rx_ready(rdy1),
    .i_bad_packet_en(ben1), .i_bad_packet(bad1),
    .o_evt_valid(evv1), .i_evt_ready(er1),
    .o_evt_need_reply(nr1), .o_evt_gratuitous(gr1),
    .o_evt_ip(ip1), .o_evt_mac(mac1), .o_busy(busy1)
`ifdef ARP_RX_STATS_EN
    , .o_cnt_req(req1), .o_cnt_rep(rep1), .o_cnt_drop(drop1)
`endif
  );

  arp_rx_parser #(.DATA_BYTES(4), .CNT_W(16)) u_dut4 (
    .i_sys_clk(clk), .i_rst(rst), .i_cfg_local_ip(local_ip),
    .i_rx_valid(v4), .i_rx_data(d4), .o_rx_ready(rdy4),
    .i_bad_packet_en(ben4), .i_bad_packet(bad4),
    .o_evt_valid(evv4), .i_evt_ready(er4),
    .o_evt_need_reply(nr4), .o_evt_gratuitous(gr4),
    .o_evt_ip(ip4), .o_evt_mac(mac4), .o_busy(busy4)
`ifdef ARP_RX_STATS_EN
    , .o_cnt_req(req4), .o_cnt_rep(rep4), .o_cnt_drop(drop4)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [15:0] oper, input logic [47:0] sha,
                       input logic [31:0] spa, input logic [31:0] tpa);
    for (int i = 0; i < 64; i++) frm[i] = 8'h00;
    frm[0] = 8'h00; frm[1] = 8'h01; frm[2] = 8'h08; frm[3] = 8'h00;
    frm[4] = 8'h06; frm[5] = 8'h04; frm[6] = oper[15:8]; frm[7] = oper[7:0];
    for (int i = 0; i < 6; i++) frm[8+i]  = sha[47-8*i -: 8];
    for (int i = 0; i < 4; i++) frm[14+i] = spa[31-8*i -: 8];
    for (int i = 0; i < 4; i++) frm[24+i] = tpa[31-8*i -: 8];
  endtask

  // One byte per beat; optional status strobe rides on the last beat.
  task automatic send1(input int n, input logic strobe, input logic bad);
    for (int i = 0; i < n; i++) begin
      v1 = 1'b1; d1 = frm[i];
      if (i == n-1 && strobe) begin ben1 = 1'b1; bad1 = bad; end
      @(posedge clk); #1;
    end
    v1 = 1'b0; d1 = '0; ben1 = 1'b0; bad1 = 1'b0;
  endtask

  // Four bytes per beat, first wire byte in the MSB lane.
  task automatic send4(input int n, input logic strobe, input logic bad);
    int beats;
    beats = (n + 3) / 4;
    for (int b = 0; b < beats; b++) begin
      v4 = 1'b1; d4 = {frm[4*b], frm[4*b+1], frm[4*b+2], frm[4*b+3]};
      if (b == beats-1 && strobe) begin
        ben4 = 1'b1; bad4 = bad;
        chk("pre_strobe_evt_valid4", 64'(evv4), 64'd0);
      end
      @(posedge clk); #1;
    end
    v4 = 1'b0; d4 = '0; ben4 = 1'b0; bad4 = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    clk = 1'b0; rst = 1'b1; local_ip = LOCAL;
    v1 = 0; d1 = '0; ben1 = 0; bad1 = 0; er1 = 0;
    v4 = 0; d4 = '0; ben4 = 0; bad4 = 0; er4 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready1", 64'(rdy1), 64'd1);
    chk("rst_evt_valid1", 64'(evv1), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_ip1", 64'(ip1), 64'd0);
    chk("rst_mac1", 64'(mac1), 64'd0);
    chk("rst_rx_ready4", 64'(rdy4), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Status strobe in IDLE is ignored
    ben1 = 1'b1; @(posedge clk); #1; ben1 = 1'b0;
    chk("idle_strobe_busy", 64'(busy1), 64'd0);
    chk("idle_strobe_evt", 64'(evv1), 64'd0);

    // Basic request, one byte per beat
    build(16'd1, 48'h001122334455, 32'hC0A8010A, LOCAL);
    send1(28, 1'b1, 1'b0);
    chk("req_evt_valid", 64'(evv1), 64'd1);
    chk("req_need_reply", 64'(nr1), 64'd1);
    chk("req_gratuitous", 64'(gr1), 64'd0);
    chk("req_ip", 64'(ip1), 64'hC0A8010A);
    chk("req_mac", 64'(mac1), 64'h001122334455);
    chk("req_rx_ready", 64'(rdy1), 64'd0);
    chk("req_busy", 64'(busy1), 64'd1);
    er1 = 1'b1; @(posedge clk); #1; er1 = 1'b0;
    chk("req_hs_evt_valid", 64'(evv1), 64'd0);
    chk("req_hs_rx_ready", 64'(rdy1), 64'd1);
    chk("req_hs_busy", 64'(busy1), 64'd0);

    // Reply with 18 padding bytes, four bytes per beat
    build(16'd2, 48'hAABBCCDDEEFF, 32'hC0A80105, LOCAL);
    er4 = 1'b1;
    send4(46, 1'b1, 1'b0);
    chk("rep_evt_valid", 64'(evv4), 64'd1);
    chk("rep_need_reply", 64'(nr4), 64'd0);
    chk("rep_gratuitous", 64'(gr4), 64'd0);
    chk("rep_ip", 64'(ip4), 64'hC0A80105);
    chk("rep_mac", 64'(mac4), 64'hAABBCCDDEEFF);
    @(posedge clk); #1; er4 = 1'b0;
    chk("rep_hs_evt_valid", 64'(evv4), 64'd0);
    chk("rep_hs_rx_ready", 64'(rdy4), 64'd1);

    // Request for another host is dropped
    build(16'd1, 48'h001122334455, 32'hC0A8010A, 32'hC0A80163);
    send1(28, 1'b1, 1'b0);
    chk("foreign_evt_valid", 64'(evv1), 64'd0);
    chk("foreign_busy", 64'(busy1), 64'd0);
    chk("foreign_rx_ready", 64'(rdy1), 64'd1);
`ifdef ARP_RX_STATS_EN
    chk("foreign_cnt_drop", 64'(drop1), 64'd1);
`endif

    // Bad frame status and illegal opcode are dropped
    build(16'd1, 48'h001122334455, 32'hC0A8010A, LOCAL);
    send1(28, 1'b1, 1'b1);
    chk("badfcs_evt_valid", 64'(evv1), 64'd0);
    chk("badfcs_busy", 64'(busy1), 64'd0);
    build(16'd3, 48'h001122334455, 32'hC0A8010A, LOCAL);
    send1(28, 1'b1, 1'b0);
    chk("oper3_evt_valid", 64'(evv1), 64'd0);
`ifdef ARP_RX_STATS_EN
    chk("drops_cnt", 64'(drop1), 64'd3);
    chk("req_cnt", 64'(req1), 64'd1);
    chk("rep_cnt4", 64'(rep4), 64'd1);
`endif

    // Back-pressured event is held
    build(16'd1, 48'h0A0B0C0D0E0F, 32'hC0A80177, LOCAL);
    send4(28, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      chk("stall_evt_valid", 64'(evv4), 64'd1);
      chk("stall_ip", 64'(ip4), 64'hC0A80177);
      chk("stall_mac", 64'(mac4), 64'h0A0B0C0D0E0F);
      chk("stall_rx_ready", 64'(rdy4), 64'd0);
      @(posedge clk); #1;
    end
    er4 = 1'b1; @(posedge clk); #1; er4 = 1'b0;
    chk("stall_hs_evt_valid", 64'(evv4), 64'd0);
    chk("stall_hs_rx_ready", 64'(rdy4), 64'd1);

    // Runt with good status
    build(16'd1, 48'h001122334455, 32'hC0A8010A, LOCAL);
    send1(20, 1'b1, 1'b0);
    chk("runt_evt_valid", 64'(evv1), 64'd0);
    chk("runt_busy", 64'(busy1), 64'd0);

    // Park the wide instance in HOLD, then reset both mid-activity
    build(16'd2, 48'h665544332211, 32'hC0A80109, LOCAL);
    send4(28, 1'b1, 1'b0);
    chk("park_evt_valid4", 64'(evv4), 64'd1);
    build(16'd1, 48'h001122334455, 32'hC0A8010A, LOCAL);
    send1(12, 1'b0, 1'b0);
    chk("midframe_busy", 64'(busy1), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy1", 64'(busy1), 64'd0);
    chk("arst_rx_ready1", 64'(rdy1), 64'd1);
    chk("arst_evt_valid4", 64'(evv4), 64'd0);
    chk("arst_ip4", 64'(ip4), 64'd0);
    chk("arst_mac4", 64'(mac4), 64'd0);
    chk("arst_need_reply4", 64'(nr4), 64'd0);
    chk("arst_rx_ready4", 64'(rdy4), 64'd1);
    chk("arst_busy4", 64'(busy4), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    send1(28, 1'b1, 1'b0);
    chk("post_rst_evt_valid", 64'(evv1), 64'd1);
    chk("post_rst_ip", 64'(ip1), 64'hC0A8010A);
    chk("post_rst_mac", 64'(mac1), 64'h001122334455);
    er1 = 1'b1; @(posedge clk); #1; er1 = 1'b0;

    // Gratuitous request
    build(16'd1, 48'h020000000001, LOCAL, LOCAL);
    send1(28, 1'b1, 1'b0);
    chk("grat_evt_valid", 64'(evv1), 64'd1);
    chk("grat_gratuitous", 64'(gr1), 64'd1);
    chk("grat_need_reply", 64'(nr1), 64'd1);
    chk("grat_ip", 64'(ip1), 64'(LOCAL));
    er1 = 1'b1; @(posedge clk); #1; er1 = 1'b0;
    chk("grat_hs_evt_valid", 64'(evv1), 64'd0);
`ifdef ARP_RX_STATS_EN
    chk("post_rst_req_cnt", 64'(req1), 64'd2);
    chk("post_rst_drop_cnt", 64'(drop1), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
